// File: rtl/spike_req_emitter_if.sv
// Bundle of the spike, handshake and status lines around spike_req_emitter.
// The master side is the neuron core plus the locker; the slave side is the emitter.
interface spike_req_emitter_if #(
    parameter int unsigned size = 2
);
    logic [size-1:0] spike_in;
    logic [size-1:0] ack_in;
    logic            clr_ovf;
    logic [size-1:0] req_out;
    logic [size-1:0] busy;
    logic [size-1:0] overflow;

    modport master (
        output spike_in,
        output ack_in,
        output clr_ovf,
        input  req_out,
        input  busy,
        input  overflow
    );

    modport slave (
        input  spike_in,
        input  ack_in,
        input  clr_ovf,
        output req_out,
        output busy,
        output overflow
    );
endinterface

// File: rtl/spike_req_emitter.sv
// Converts single-cycle spike pulses into 4-phase req/ack handshakes, one per
// accepted spike and per channel. Bursts queue in a saturating pending counter.
// The asynchronous ack lines are synchronised before the FSMs look at them.
module spike_req_emitter #(
    parameter int unsigned size        = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    spike_req_emitter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StReqHi,
        StReqLo
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [size-1:0]  sync_q [SYNC_STAGES];
    logic [size-1:0]  ack_s;

    state_e           state_q [size];
    state_e           state_d [size];
    logic [CNT_W-1:0] cnt_q   [size];
    logic [CNT_W-1:0] cnt_d   [size];
    logic [size-1:0]  deq;
    logic [size-1:0]  req_q, req_d;
    logic [size-1:0]  busy_q, busy_d;
    logic [size-1:0]  ovf_q, ovf_d;

    // Multi-flop synchroniser bringing ack_in into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.ack_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Per-channel handshake FSM, pending counter and sticky overflow next-state.
    always_comb begin
        deq    = '0;
        req_d  = '0;
        busy_d = '0;
        ovf_d  = '0;
        for (int i = 0; i < size; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            ovf_d[i]   = ovf_q[i] & ~bus.clr_ovf;

            case (state_q[i])
                StIdle: begin
                    // A high ack_s here is stale; wait for it to drop before requesting.
                    if (cnt_q[i] != '0 && !ack_s[i]) begin
                        state_d[i] = StReqHi;
                        deq[i]     = 1'b1;
                    end
                end
                StReqHi: begin
                    if (ack_s[i]) begin
                        state_d[i] = StReqLo;
                    end
                end
                StReqLo: begin
                    if (!ack_s[i]) begin
                        state_d[i] = StIdle;
                    end
                end
                default: state_d[i] = StIdle;
            endcase

            if (bus.spike_in[i] && !deq[i]) begin
                // A drop sets the flag even when clr_ovf is asserted in the same cycle.
                if (cnt_q[i] == CntMax) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!bus.spike_in[i] && deq[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end

            req_d[i]  = (state_d[i] == StReqHi);
            busy_d[i] = (state_d[i] != StIdle) || (cnt_d[i] != '0);
        end
    end

    // State, counters and registered outputs; req leaves straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < size; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            req_q  <= '0;
            busy_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < size; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            req_q  <= req_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.req_out  = req_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;

endmodule
